// File: rtl/restoring_div_4b.sv
// Sequential 4-bit unsigned restoring divider: one shift-subtract step per clock
// through a single ripple subtractor, with divide-by-zero short-circuit.

module full_sub_1b (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);
  assign diff_o = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

module full_sub_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       carry
);
  logic [4:0] bw;

  assign bw[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    full_sub_1b u_bit (
      .a_i    (a[i]),
      .b_i    (b[i]),
      .bin_i  (bw[i]),
      .diff_o (sum[i]),
      .bout_o (bw[i+1])
    );
  end

  assign carry = bw[4];
endmodule

module restoring_div_4b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q;
  logic [1:0] cnt_q;
  logic [3:0] q_q, r_q, d_q;
  logic [3:0] quot_q, rem_q;
  logic       busy_q, done_q, dz_q;

  logic [4:0] s;
  logic [3:0] diff;
  logic       bw, ok;
  logic [3:0] q_d, r_d;

  full_sub_4b u_sub (
    .a     (s[3:0]),
    .b     (d_q),
    .sum   (diff),
    .carry (bw)
  );

  // S[4]=1 means S >= 16 > D, so the step succeeds and the 4-bit diff is exact.
  always_comb begin
    s   = {r_q, q_q[3]};
    ok  = s[4] | ~bw;
    r_d = ok ? diff : s[3:0];
    q_d = {q_q[2:0], ok};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      q_q     <= 4'd0;
      r_q     <= 4'd0;
      d_q     <= 4'd0;
      quot_q  <= 4'd0;
      rem_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor != 4'd0) begin
              d_q     <= divisor;
              q_q     <= dividend;
              r_q     <= 4'd0;
              cnt_q   <= 2'd0;
              dz_q    <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else begin
              quot_q  <= 4'hF;
              rem_q   <= dividend;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            quot_q  <= q_d;
            rem_q   <= r_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;
endmodule

// File: tb/tb_restoring_div_4b.sv
// Scoreboard bench for restoring_div_4b: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.

module tb_restoring_div_4b;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = 4'd0;
  logic [3:0] divisor = 4'd0;
  logic       busy, done, div_zero;
  logic [3:0] quotient, remainder;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  restoring_div_4b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division; zero divisor gives all-ones quotient.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = 4'hF; e.r = a[3:0]; e.dz = 1'b1;
    end else begin
      e.q = 4'(a / b); e.r = 4'(a % b); e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: q=%0d r=%0d dz=%0d", quotient, remainder, div_zero);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_quotient", quotient, e.q);
        chk("sb_remainder", remainder, e.r);
        chk("sb_div_zero", div_zero, e.dz);
      end
    end
  end

  task automatic issue(input int a, input int b, input bit push);
    @(negedge clk);
    start = 1'b1; dividend = 4'(a); divisor = 4'(b);
    if (push) exp_q.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset with start asserted: must not be accepted.
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dz", div_zero, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // 13 / 3 with cycle-accurate timing.
    issue(13, 3, 1'b1);
    chk("t13_busy_e0", busy, 1);
    chk("t13_done_e0", done, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t13_busy_run", busy, 1);
      chk("t13_done_run", done, 0);
    end
    @(negedge clk);
    chk("t13_busy_e4", busy, 0);
    chk("t13_done_e4", done, 1);
    @(negedge clk);
    chk("t13_done_e5", done, 0);
    repeat (10) @(negedge clk);
    chk("t13_hold_q", quotient, 4);
    chk("t13_hold_r", remainder, 1);

    // Boundary values.
    issue(15, 1, 1'b1);  wait_done("b15_1");
    issue(7, 9, 1'b1);   wait_done("b7_9");
    issue(15, 15, 1'b1); wait_done("b15_15");
    issue(0, 5, 1'b1);   wait_done("b0_5");
    issue(14, 8, 1'b1);  wait_done("b14_8");

    // Divide by zero: done in the cycle right after acceptance, busy never high.
    issue(9, 0, 1'b1);
    chk("z_done_e0", done, 1);
    chk("z_dz_e0", div_zero, 1);
    chk("z_busy_e0", busy, 0);
    @(negedge clk);
    chk("z_done_e1", done, 0);
    chk("z_busy_e1", busy, 0);

    // Start ignored during RUN; held start re-accepted at E6.
    @(negedge clk);
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    exp_q.push_back(model(12, 5));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd15; divisor = 4'd1;
    exp_q.push_back(model(15, 1));
    repeat (3) @(negedge clk);
    chk("ign_done_e4", done, 1);
    chk("ign_q_e4", quotient, 2);
    chk("ign_r_e4", remainder, 2);
    @(negedge clk);
    chk("ign_busy_e5", busy, 0);
    @(negedge clk);
    chk("ign_busy_e6", busy, 1);
    start = 1'b0;
    wait_done("reaccept");

    // Reset in the middle of an 11 / 2.
    @(negedge clk);
    start = 1'b1; dividend = 4'd11; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_quot", quotient, 0);
    chk("mrst_rem", remainder, 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mrst_no_done", done, 0);
    issue(11, 2, 1'b1); wait_done("mrst_11_2");

    // Randomized operands, about one in five with a zero divisor.
    for (int n = 0; n < 40; n++) begin
      int a, b;
      a = $urandom_range(15, 0);
      b = ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(15, 1);
      issue(a, b, 1'b1);
      wait_done("rand");
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
